// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: default geometry and the
// {push,pop} strobe encodings used by the controller, stack and testbench.
package stack_pkg;

    localparam int unsigned STACK_WIDTH = 8;
    localparam int unsigned STACK_DEPTH = 16;
    localparam int unsigned STACK_PTR_W = $clog2(STACK_DEPTH) + 1;

    typedef logic [1:0] stack_op_t;

    localparam stack_op_t OP_NONE = 2'b00;
    localparam stack_op_t OP_POP  = 2'b01;
    localparam stack_op_t OP_PUSH = 2'b10;
    localparam stack_op_t OP_REPL = 2'b11;

    function automatic stack_op_t stack_op(input logic push, input logic pop);
        return {push, pop};
    endfunction

endpackage

// File: rtl/stack_unit_if.sv
// Controller <-> operand stack signal bundle: one-cycle strobes toward the
// stack, top-of-stack word and status back toward the controller.
interface stack_unit_if
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = STACK_WIDTH,
    parameter int unsigned PTR_W = STACK_PTR_W
);
    logic             push;
    logic             pop;
    logic             tos;
    logic [WIDTH-1:0] push_data;
    logic             err_clr;
    logic [WIDTH-1:0] top_data;
    logic [PTR_W-1:0] count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, tos, push_data, err_clr,
        input  top_data, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, tos, push_data, err_clr,
        output top_data, count, empty, full, overflow, underflow
    );

endinterface

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH stack storage: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
module stack_regfile #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_unit.sv
// Hardware LIFO operand stack: decodes push/pop/tos strobes, keeps the stack
// pointer and sticky error flags, and presents a zero-latency top-of-stack.
module stack_unit
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = STACK_WIDTH,
    parameter int unsigned DEPTH = STACK_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH) + 1
) (
    input logic         clk,
    input logic         rst,
    stack_unit_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [PTR_W-1:0] sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ovf_evt, unf_evt;
    logic             is_empty, is_full;
    stack_op_t        op;
    logic             we;
    logic [AW-1:0]    waddr, raddr;
    logic [WIDTH-1:0] rdata;

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == PTR_W'(DEPTH));
    assign op       = stack_op(bus.push, bus.pop);
    // Wraps to DEPTH-1 when empty; top_data masks that case to zero.
    assign raddr    = AW'(sp_q - PTR_W'(1));

    always_comb begin
        sp_d    = sp_q;
        we      = 1'b0;
        waddr   = sp_q[AW-1:0];
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        case (op)
            OP_NONE: ;
            OP_PUSH: begin
                if (is_full) begin
                    ovf_evt = 1'b1;
                end else begin
                    we   = 1'b1;
                    sp_d = sp_q + PTR_W'(1);
                end
            end
            OP_POP: begin
                if (is_empty) begin
                    unf_evt = 1'b1;
                end else begin
                    sp_d = sp_q - PTR_W'(1);
                end
            end
            OP_REPL: begin
                we = 1'b1;
                if (is_empty) begin
                    waddr   = '0;
                    sp_d    = PTR_W'(1);
                    unf_evt = 1'b1;
                end else begin
                    waddr = raddr;
                end
            end
            default: ;
        endcase
        if (bus.tos && is_empty && !bus.push) begin
            unf_evt = 1'b1;
        end
        // A fresh error in the same cycle takes priority over err_clr.
        ovf_d = ovf_evt | (ovf_q & ~bus.err_clr);
        unf_d = unf_evt | (unf_q & ~bus.err_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(AW)
    ) u_regfile (
        .clk    (clk),
        .we_i   (we & rst),
        .waddr_i(waddr),
        .wdata_i(bus.push_data),
        .raddr_i(raddr),
        .rdata_o(rdata)
    );

    assign bus.top_data  = is_empty ? '0 : rdata;
    assign bus.count     = sp_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: a queue-based reference stack predicts the
// post-edge status snapshot and the pre-edge top word for every driven cycle.
module tb_stack_unit;
    import stack_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 16;
    localparam int unsigned PW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stack_unit_if #(.WIDTH(W), .PTR_W(PW)) bus ();

    stack_unit #(.WIDTH(W), .DEPTH(D), .PTR_W(PW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // {count, empty, full, overflow, underflow, top_data}
    typedef logic [PW+4+W-1:0] snap_t;

    logic [W-1:0] mdl [$];
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;
    snap_t        exp_q [$];
    logic [W-1:0] pre_exp_q [$];
    logic [W-1:0] pre_obs_q [$];
    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;

    function automatic snap_t dut_snap();
        return {bus.count, bus.empty, bus.full, bus.overflow, bus.underflow, bus.top_data};
    endfunction

    function automatic snap_t mdl_snap();
        logic [W-1:0] t;
        int sz;
        sz = mdl.size();
        t  = (sz != 0) ? mdl[sz-1] : '0;
        return {PW'(sz), (sz == 0), (sz == int'(D)), m_ovf, m_unf, t};
    endfunction

    task automatic drive(input logic p, input logic po, input logic t,
                         input logic [W-1:0] d, input logic clr, input logic r);
        logic ev_o, ev_u;
        int   sz;
        pre_exp_q.delete();
        pre_obs_q.delete();
        @(negedge clk);
        bus.push = p; bus.pop = po; bus.tos = t; bus.push_data = d; bus.err_clr = clr; rst = r;
        #1;
        pre_obs_q.push_back(bus.top_data);
        sz = mdl.size();
        pre_exp_q.push_back((sz != 0) ? mdl[sz-1] : '0);
        ev_o = 1'b0;
        ev_u = 1'b0;
        if (!r) begin
            mdl.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (p && !po) begin
                if (sz == int'(D)) ev_o = 1'b1;
                else mdl.push_back(d);
            end else if (!p && po) begin
                if (sz == 0) ev_u = 1'b1;
                else void'(mdl.pop_back());
            end else if (p && po) begin
                if (sz == 0) begin
                    mdl.push_back(d);
                    ev_u = 1'b1;
                end else begin
                    mdl[sz-1] = d;
                end
            end
            if (t && !p && sz == 0) ev_u = 1'b1;
            m_ovf = ev_o | (m_ovf & ~clr);
            m_unf = ev_u | (m_unf & ~clr);
        end
        exp_q.push_back(mdl_snap());
        @(posedge clk);
        #1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0; bus.err_clr = 1'b0; rst = 1'b1;
    endtask

    task automatic test_reset();
        snap_t got, want;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        got = dut_snap(); want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL reset_snap: got %h want %h", got, want); end
        n_vec++;
        if ({bus.count, bus.empty, bus.full, bus.top_data} !== {5'd0, 1'b1, 1'b0, 8'h00}) begin
            n_err++; $display("FAIL reset_const: got cnt=%0d e=%b f=%b top=%h", bus.count, bus.empty, bus.full, bus.top_data);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1);
        got = dut_snap(); want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL reset_idle: got %h want %h", got, want); end
    endtask

    task automatic test_push_pop();
        snap_t got, want;
        logic [W-1:0] vals [3];
        logic [W-1:0] pobs, pexp;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, vals[i], 1'b0, 1'b1);
            got = dut_snap(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL push_%0d: got %h want %h", i, got, want); end
        end
        n_vec++;
        if (bus.count !== 5'd3 || bus.top_data !== 8'h33) begin
            n_err++; $display("FAIL push3_const: got cnt=%0d top=%h want 3/33", bus.count, bus.top_data);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
            pobs = pre_obs_q.pop_front(); pexp = pre_exp_q.pop_front(); n_vec++;
            if (pobs !== pexp) begin n_err++; $display("FAIL pop_pre_%0d: got %h want %h", i, pobs, pexp); end
            got = dut_snap(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL pop_%0d: got %h want %h", i, got, want); end
            if (i == 0) begin
                n_vec++;
                if (pobs !== 8'h33 || bus.top_data !== 8'h22 || bus.count !== 5'd2) begin
                    n_err++; $display("FAIL pop_const: got pre=%h top=%h cnt=%0d want 33/22/2", pobs, bus.top_data, bus.count);
                end
            end
        end
    endtask

    task automatic test_fill_overflow();
        snap_t got, want;
        logic [W-1:0] pobs;
        for (int i = 0; i < int'(D); i++) begin
            drive(1'b1, 1'b0, 1'b0, W'(i), 1'b0, 1'b1);
            got = dut_snap(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL fill_%0d: got %h want %h", i, got, want); end
        end
        drive(1'b1, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1);
        got = dut_snap(); want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL push_full: got %h want %h", got, want); end
        n_vec++;
        if ({bus.full, bus.count, bus.overflow, bus.top_data} !== {1'b1, 5'd16, 1'b1, 8'h0F}) begin
            n_err++; $display("FAIL ovf_const: got f=%b cnt=%0d ovf=%b top=%h", bus.full, bus.count, bus.overflow, bus.top_data);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        got = dut_snap(); want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL ovf_clr: got %h want %h", got, want); end
        for (int i = 0; i < int'(D); i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
            pobs = pre_obs_q.pop_front(); void'(pre_exp_q.pop_front()); n_vec++;
            if (pobs !== W'(int'(D) - 1 - i)) begin
                n_err++; $display("FAIL drain_pre_%0d: got %h want %h", i, pobs, W'(int'(D) - 1 - i));
            end
            got = dut_snap(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL drain_%0d: got %h want %h", i, got, want); end
        end
    endtask

    task automatic test_underflow();
        snap_t got, want;
        // pop, tos, pop+err_clr, err_clr: underflow sticks until a clean clear
        logic [3:0] pops = 4'b0101;
        logic [3:0] toss = 4'b0010;
        logic [3:0] clrs = 4'b1100;
        logic [3:0] unf  = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, pops[i], toss[i], 8'h00, clrs[i], 1'b1);
            got = dut_snap(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL unf_step_%0d: got %h want %h", i, got, want); end
            n_vec++;
            if (bus.underflow !== unf[i] || bus.count !== 5'd0) begin
                n_err++; $display("FAIL unf_const_%0d: got unf=%b cnt=%0d want %b/0", i, bus.underflow, bus.count, unf[i]);
            end
        end
    endtask

    task automatic test_replace();
        snap_t got, want;
        drive(1'b1, 1'b0, 1'b0, 8'h05, 1'b0, 1'b1); void'(exp_q.pop_front());
        drive(1'b1, 1'b0, 1'b0, 8'h07, 1'b0, 1'b1); void'(exp_q.pop_front());
        drive(1'b1, 1'b1, 1'b0, 8'h0C, 1'b0, 1'b1);
        got = dut_snap(); want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL repl: got %h want %h", got, want); end
        n_vec++;
        if (bus.count !== 5'd2 || bus.top_data !== 8'h0C) begin
            n_err++; $display("FAIL repl_const: got cnt=%0d top=%h want 2/0c", bus.count, bus.top_data);
        end
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        got = dut_snap(); want = exp_q.pop_front(); n_vec++;
        if (got !== want || bus.top_data !== 8'h05) begin
            n_err++; $display("FAIL repl_below: got %h want %h", got, want);
        end
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1); void'(exp_q.pop_front());
        for (int i = 0; i < int'(D); i++) begin
            drive(1'b1, 1'b0, 1'b0, W'(8'hE0 + i), 1'b0, 1'b1); void'(exp_q.pop_front());
        end
        drive(1'b1, 1'b1, 1'b0, 8'h99, 1'b0, 1'b1);
        got = dut_snap(); want = exp_q.pop_front(); n_vec++;
        if (got !== want || bus.overflow !== 1'b0 || bus.top_data !== 8'h99) begin
            n_err++; $display("FAIL repl_full: got %h want %h", got, want);
        end
        drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        got = dut_snap(); want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL tos_nonempty: got %h want %h", got, want); end
        for (int i = 0; i < int'(D); i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1); void'(exp_q.pop_front());
        end
        drive(1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1);
        got = dut_snap(); want = exp_q.pop_front(); n_vec++;
        if (got !== want || {bus.count, bus.underflow, bus.top_data} !== {5'd1, 1'b1, 8'h3C}) begin
            n_err++; $display("FAIL repl_empty: got %h want %h", got, want);
        end
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1); void'(exp_q.pop_front());
    endtask

    task automatic test_reset_mid();
        snap_t got, want;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, W'(8'h70 + i), 1'b0, 1'b1); void'(exp_q.pop_front());
        end
        drive(1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0);
        got = dut_snap(); want = exp_q.pop_front(); n_vec++;
        if (got !== want || bus.count !== 5'd0 || bus.empty !== 1'b1) begin
            n_err++; $display("FAIL rst_mid: got %h want %h", got, want);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h44, 1'b0, 1'b1);
        got = dut_snap(); want = exp_q.pop_front(); n_vec++;
        if (got !== want || bus.count !== 5'd1 || bus.top_data !== 8'h44) begin
            n_err++; $display("FAIL rst_mid_push: got %h want %h", got, want);
        end
    endtask

    task automatic test_back_to_back();
        snap_t got, want;
        logic [W-1:0] pobs, pexp;
        logic p, po, t, c;
        for (int i = 0; i < 120; i++) begin
            p  = ($urandom_range(0, 9) < 6);
            po = ($urandom_range(0, 9) < 4);
            t  = ($urandom_range(0, 9) < 2);
            c  = ($urandom_range(0, 9) < 1);
            drive(p, po, t, W'($urandom), c, 1'b1);
            pobs = pre_obs_q.pop_front(); pexp = pre_exp_q.pop_front(); n_vec++;
            if (pobs !== pexp) begin n_err++; $display("FAIL b2b_pre_%0d: got %h want %h", i, pobs, pexp); end
            got = dut_snap(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL b2b_%0d: got %h want %h", i, got, want); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0;
        bus.push_data = '0; bus.err_clr = 1'b0;
        test_reset();
        test_push_pop();
        test_fill_overflow();
        test_underflow();
        test_replace();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Hardware LIFO operand stack for the stack-based multicycle processor.
- Sits between the controller and the A/B operand registers.
- Takes the controller's push/pop/tos strobes and the push-source-muxed write data. Supplies the current top-of-stack word to the datapath.
- Also reports depth, full/empty status and sticky overflow/underflow error flags.

Parameters:
- WIDTH, 8, data word width in bits (matches memory/ALU word).
- DEPTH, 16, number of stack entries; must be a power of two, at least 2.
- PTR_W, $clog2(DEPTH)+1, stack-pointer/count width (holds 0..DEPTH).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous reset, active-low: 0 resets the block on the next rising clk edge.
- push  in  1  write push_data onto stack this cycle.
- pop  in  1  discard top entry this cycle.
- tos  in  1  top-of-stack read qualifier; no state change.
- push_data  in  WIDTH  word to push, already selected by the datapath push_src mux.
- err_clr  in  1  clears the sticky error flags.
- top_data  out  WIDTH  current top entry, combinational from stack state.
- count  out  PTR_W  number of valid entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop or tos attempted while empty.

Behaviour:
- Reset (rst==0 at the clk edge):
  - sp=0, overflow=0, underflow=0.
  - Storage array is not reset.
  - Resulting outputs: count=0, empty=1, full=0, top_data=0.
  - Reset overrides every other input in the same cycle, including mid-sequence push/pop.
- State: sp register, 0..DEPTH. Valid entries are mem[0..sp-1]; the top is mem[sp-1].
- top_data:
  - Equals mem[sp-1] when sp!=0, else all zeros.
  - Purely combinational (zero latency), so the controller can latch it into A in the same cycle it asserts pop.
  - Read-before-update: top_data shows the pre-edge top during a pop/push cycle.
- Operations, decoded from {push,pop}:
  - 00: no change.
  - 10, push only:
    - If !full: mem[sp] <= push_data, sp <= sp+1.
    - If full: no write, sp unchanged, overflow <= 1.
  - 01, pop only:
    - If !empty: sp <= sp-1, no data movement.
    - If empty: sp unchanged, underflow <= 1.
  - 11, push+pop (replace top):
    - If !empty: mem[sp-1] <= push_data, sp unchanged. Never overflows, even when full.
    - If empty: treated as push only (mem[0] <= push_data, sp <= 1), and underflow <= 1.
- tos with empty (and no push that cycle): underflow <= 1. Otherwise tos has no effect on state.
- err_clr: clears both sticky flags at the edge. A new error event in the same cycle wins over the clear (flag remains 1).
- count, empty and full are registered-state derived; they update the cycle after the operation.
- No wrap-around: sp saturates at 0 and DEPTH. Illegal operations never corrupt existing entries.
- Single clock domain; no handshake beyond the one-cycle strobes. Strobes are sampled only on the rising clk edge.

Decomposition:
- Shared package (stack_pkg):
  - WIDTH/DEPTH defaults.
  - Localparam op encodings OP_NONE=2'b00, OP_POP=2'b01, OP_PUSH=2'b10, OP_REPL=2'b11.
  - Reused by controller and testbench.
- One sub-module, stack_regfile:
  - DEPTH x WIDTH array with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
  - stack_unit holds sp, the op decode, the error flags and the top_data zero-masking.

Test Plan:
- Reset, then idle: rst=0 one cycle -> count=0, empty=1, full=0, top_data=8'h00, overflow=underflow=0.
- Push 8'h11, 8'h22, 8'h33 -> count=3, top_data=8'h33. Pop with top_data sampled in the same cycle -> sampled 8'h33; next cycle top_data=8'h22, count=2.
- Fill to DEPTH=16 with 8'h00..8'h0F, then push 8'hAA:
  - full=1, count=16, overflow=1, top_data=8'h0F.
  - Then err_clr -> overflow=0.
  - Pop 16 times -> sequence 8'h0F down to 8'h00, then empty=1.
- On empty: pop, then tos -> underflow=1, count stays 0. Same cycle err_clr=1 with pop -> underflow stays 1. Next cycle err_clr alone -> underflow=0.
- Replace: stack {8'h05,8'h07}, push=pop=1 with push_data=8'h0C -> count=2, top_data=8'h0C, entry below still 8'h05. At full, push+pop -> overflow stays 0.
- Reset mid-operation: 3 entries, rst=0 coincident with push=1 -> count=0, empty=1. Subsequent push 8'h44 -> count=1, top_data=8'h44.
